// File: rtl/sha3_pad_sequencer_pkg.sv
// Shared types and constants for the SHA3 padding front-end.
package sha3_pkg;

  typedef enum logic [1:0] {
    SHA224 = 2'd0,
    SHA256 = 2'd1,
    SHA384 = 2'd2,
    SHA512 = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ABSORB = 2'd1,
    PAD    = 2'd2
  } state_t;

  localparam logic [7:0] PAD_FIRST = 8'h06;
  localparam logic [7:0] PAD_LAST  = 8'h80;

  // Keccak rate expressed in 16-bit words for each variant.
  function automatic logic [6:0] rate_words(mode_t m);
    case (m)
      SHA224:  return 7'd72;
      SHA256:  return 7'd68;
      SHA384:  return 7'd52;
      default: return 7'd36;
    endcase
  endfunction

endpackage

// File: rtl/sha3_pad_sequencer_axis_reg_slice.sv
// Single-stage forward register slice: 1-cycle latency, loads whenever empty or draining.
// Outputs hold stable while valid and not ready.
module axis_reg_slice #(
  parameter int          DW       = 16,
  parameter int          UW       = 2,
  parameter logic [UW-1:0] USER_RST = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [DW-1:0] in_data,
  input  logic [UW-1:0] in_user,
  input  logic          in_id,
  input  logic          in_last,
  output logic          can_load,
  output logic [DW-1:0] out_data,
  output logic [UW-1:0] out_user,
  output logic          out_id,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready
);

  assign can_load = !out_valid || out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_user  <= USER_RST;
      out_id    <= 1'b0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
    end else if (load) begin
      out_data  <= in_data;
      out_user  <= in_user;
      out_id    <= in_id;
      out_last  <= in_last;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sha3_pad_sequencer.sv
// Splits a 16-bit AXI-Stream message into SHA3 rate blocks and appends 0x06..0x80 padding.
// One-cycle latency through an output slice; source is stalled during padding and core backpressure.
module sha3_pad_sequencer
  import sha3_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             ACLK,
  input  logic             ARESET,
  input  logic [WIDTH-1:0] s_TDATA,
  input  logic [1:0]       s_TKEEP,
  input  logic             s_TLAST,
  input  logic [1:0]       s_TUSER,
  input  logic             s_TVALID,
  output logic             s_TREADY,
  output logic [WIDTH-1:0] c_TDATA,
  output logic [1:0]       c_TUSER,
  output logic             c_TID,
  output logic             c_TLAST,
  output logic             c_TVALID,
  input  logic             c_TREADY,
  output logic             busy,
  output logic [CNT_W-1:0] blk_cnt,
  output logic             err
);

  state_t           state, state_nxt;
  mode_t            mode, mode_nxt, cur_mode;
  logic [6:0]       w, w_nxt, r_last;
  logic             pend, pend_nxt;
  logic             busy_nxt, err_nxt;
  logic [CNT_W-1:0] cnt_nxt, cnt_base;
  logic             blk_inc;
  logic             can_load, take, at_end;
  logic [1:0]       keep_eff;
  logic             ld, ld_id, ld_last;
  logic [WIDTH-1:0] ld_data;

  // The mode is only sampled from the bus on the first beat of a message.
  assign cur_mode = (state == IDLE) ? mode_t'(s_TUSER) : mode;
  assign r_last   = rate_words(cur_mode) - 7'd1;
  assign at_end   = (w == r_last);
  assign s_TREADY = (state != PAD) && can_load;
  assign take     = s_TVALID && s_TREADY;
  assign keep_eff = (s_TKEEP == 2'b10) ? 2'b11 : s_TKEEP;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state   <= IDLE;
      mode    <= SHA256;
      w       <= '0;
      pend    <= 1'b0;
      busy    <= 1'b0;
      blk_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      mode    <= mode_nxt;
      w       <= w_nxt;
      pend    <= pend_nxt;
      busy    <= busy_nxt;
      blk_cnt <= cnt_nxt;
      err     <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    mode_nxt  = mode;
    w_nxt     = w;
    pend_nxt  = pend;
    busy_nxt  = busy;
    err_nxt   = err;
    cnt_base  = blk_cnt;
    blk_inc   = 1'b0;
    ld        = 1'b0;
    ld_data   = '0;
    ld_id     = 1'b0;
    ld_last   = 1'b0;
    cnt_nxt   = blk_cnt;

    case (state)
      IDLE, ABSORB: begin
        if (take) begin
          if (state == IDLE) begin
            mode_nxt  = cur_mode;
            busy_nxt  = 1'b1;
            cnt_base  = '0;
            state_nxt = ABSORB;
          end
          if (!s_TLAST) begin
            ld      = 1'b1;
            ld_data = s_TDATA;
            if (s_TKEEP != 2'b11) err_nxt = 1'b1;
          end else begin
            if (s_TKEEP == 2'b10) err_nxt = 1'b1;
            state_nxt = PAD;
            pend_nxt  = 1'b1;
            case (keep_eff)
              2'b11: begin
                ld      = 1'b1;
                ld_data = s_TDATA;
              end
              2'b01: begin
                // The 0x06 domain byte lands in the upper half of the partial word.
                ld       = 1'b1;
                pend_nxt = 1'b0;
                ld_data  = {PAD_FIRST, s_TDATA[7:0]};
                if (at_end) begin
                  ld_data   = {PAD_FIRST | PAD_LAST, s_TDATA[7:0]};
                  ld_last   = 1'b1;
                  state_nxt = IDLE;
                  busy_nxt  = 1'b0;
                end
              end
              default: ;
            endcase
          end
        end
      end
      PAD: begin
        if (can_load) begin
          ld       = 1'b1;
          pend_nxt = 1'b0;
          ld_data  = {(at_end ? PAD_LAST : 8'h00), (pend ? PAD_FIRST : 8'h00)};
          if (at_end) begin
            ld_last   = 1'b1;
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (ld) begin
      ld_id = at_end;
      if (at_end) begin
        w_nxt   = '0;
        blk_inc = 1'b1;
      end else begin
        w_nxt = w + 7'd1;
      end
    end

    cnt_nxt = (blk_inc && (cnt_base != '1)) ? cnt_base + 1'b1 : cnt_base;
  end

  axis_reg_slice #(
    .DW       (WIDTH),
    .UW       (2),
    .USER_RST (2'd1)
  ) u_slice (
    .clk       (ACLK),
    .rst       (ARESET),
    .load      (ld),
    .in_data   (ld_data),
    .in_user   (cur_mode),
    .in_id     (ld_id),
    .in_last   (ld_last),
    .can_load  (can_load),
    .out_data  (c_TDATA),
    .out_user  (c_TUSER),
    .out_id    (c_TID),
    .out_last  (c_TLAST),
    .out_valid (c_TVALID),
    .out_ready (c_TREADY)
  );

endmodule

// File: tb/tb_sha3_pad_sequencer.sv
// Directed bench: message vectors are checked against a byte-level SHA3 padding model and hand values.
module tb_sha3_pad_sequencer;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [15:0] s_TDATA = '0;
  logic [1:0]  s_TKEEP = '0;
  logic        s_TLAST = 1'b0;
  logic [1:0]  s_TUSER = '0;
  logic        s_TVALID = 1'b0;
  logic        s_TREADY;
  logic [15:0] c_TDATA;
  logic [1:0]  c_TUSER;
  logic        c_TID;
  logic        c_TLAST;
  logic        c_TVALID;
  logic        c_TREADY = 1'b1;
  logic        busy;
  logic [15:0] blk_cnt;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [1:0]  mode;
    int          n_full;
    logic [15:0] last_dat;
    logic [1:0]  last_keep;
    logic [1:0]  first_keep;
    bit          stall;
    int          exp_len;
    int          exp_blk;
    int          chk_idx;
    logic [15:0] chk_val;
    bit          exp_err;
  } vec_t;

  vec_t vecs[7];

  logic [15:0] got_d[$];
  bit          got_id[$];
  bit          got_last[$];
  logic [1:0]  got_user[$];
  logic [15:0] exp_d[$];
  bit          exp_id[$];
  bit          exp_last[$];

  sha3_pad_sequencer #(.WIDTH(16), .CNT_W(16)) dut (
    .ACLK     (ACLK),
    .ARESET   (ARESET),
    .s_TDATA  (s_TDATA),
    .s_TKEEP  (s_TKEEP),
    .s_TLAST  (s_TLAST),
    .s_TUSER  (s_TUSER),
    .s_TVALID (s_TVALID),
    .s_TREADY (s_TREADY),
    .c_TDATA  (c_TDATA),
    .c_TUSER  (c_TUSER),
    .c_TID    (c_TID),
    .c_TLAST  (c_TLAST),
    .c_TVALID (c_TVALID),
    .c_TREADY (c_TREADY),
    .busy     (busy),
    .blk_cnt  (blk_cnt),
    .err      (err)
  );

  always #5 ACLK = ~ACLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rate_of(input logic [1:0] m);
    int rates[4] = '{72, 68, 52, 36};
    return rates[m];
  endfunction

  function automatic logic [15:0] full_word(input int i);
    return 16'hA500 + 16'(i);
  endfunction

  // Reference padding: message bytes, then 0x06, zero fill to the rate, 0x80 ORed into the final byte.
  task automatic build_exp(input vec_t v);
    logic [7:0] b[$];
    logic [15:0] fw;
    int rb, nw, r;
    exp_d.delete(); exp_id.delete(); exp_last.delete();
    r = rate_of(v.mode);
    rb = 2 * r;
    for (int i = 0; i < v.n_full; i++) begin
      fw = full_word(i);
      b.push_back(fw[7:0]);
      b.push_back(fw[15:8]);
    end
    if (v.last_keep == 2'b01) begin
      b.push_back(v.last_dat[7:0]);
    end else if (v.last_keep != 2'b00) begin
      b.push_back(v.last_dat[7:0]);
      b.push_back(v.last_dat[15:8]);
    end
    b.push_back(8'h06);
    while ((b.size() % rb) != 0) b.push_back(8'h00);
    b[b.size()-1] = b[b.size()-1] | 8'h80;
    nw = b.size() / 2;
    for (int i = 0; i < nw; i++) begin
      exp_d.push_back({b[2*i+1], b[2*i]});
      exp_id.push_back(((i + 1) % r) == 0);
      exp_last.push_back(i == nw - 1);
    end
  endtask

  task automatic run_msg(input vec_t v, input string tag);
    int beat, nbeats, cyc, stab_err, d_err, id_err, last_err, user_err;
    logic [15:0] hold_d;
    logic hold_id, hold_last, stalled;
    bit done;
    got_d.delete(); got_id.delete(); got_last.delete(); got_user.delete();
    build_exp(v);
    nbeats = v.n_full + 1;
    beat = 0; cyc = 0; stab_err = 0; stalled = 1'b0; done = 1'b0;
    hold_d = '0; hold_id = 1'b0; hold_last = 1'b0;
    while (!done && cyc < 3000) begin
      @(negedge ACLK);
      cyc++;
      c_TREADY = v.stall ? cyc[0] : 1'b1;
      if (beat < nbeats) begin
        s_TVALID = 1'b1;
        s_TLAST  = (beat == nbeats - 1);
        s_TDATA  = s_TLAST ? v.last_dat : full_word(beat);
        s_TKEEP  = s_TLAST ? v.last_keep : v.first_keep;
        s_TUSER  = (beat == 0) ? v.mode : ~v.mode;
      end else begin
        s_TVALID = 1'b0;
        s_TLAST  = 1'b0;
      end
      #1;
      if (stalled && (c_TDATA !== hold_d || c_TID !== hold_id || c_TLAST !== hold_last)) stab_err++;
      stalled   = c_TVALID && !c_TREADY;
      hold_d    = c_TDATA;
      hold_id   = c_TID;
      hold_last = c_TLAST;
      if (s_TVALID && s_TREADY) beat++;
      if (c_TVALID && c_TREADY) begin
        got_d.push_back(c_TDATA);
        got_id.push_back(c_TID);
        got_last.push_back(c_TLAST);
        got_user.push_back(c_TUSER);
        if (c_TLAST) done = 1'b1;
      end
    end
    @(negedge ACLK);
    s_TVALID = 1'b0;
    s_TLAST  = 1'b0;
    c_TREADY = 1'b1;
    #1;
    check({tag, " finished"}, 32'(done), 32'd1);
    check({tag, " word count"}, got_d.size(), v.exp_len);
    check({tag, " model length"}, got_d.size(), exp_d.size());
    d_err = 0; id_err = 0; last_err = 0; user_err = 0;
    for (int i = 0; i < got_d.size() && i < exp_d.size(); i++) begin
      if (got_d[i] !== exp_d[i]) begin
        d_err++;
        if (d_err <= 3) $display("  %s word %0d: %h vs %h", tag, i, got_d[i], exp_d[i]);
      end
      if (got_id[i] !== exp_id[i]) id_err++;
      if (got_last[i] !== exp_last[i]) last_err++;
      if (got_user[i] !== v.mode) user_err++;
    end
    check({tag, " data words wrong"}, d_err, 0);
    check({tag, " c_TID positions wrong"}, id_err, 0);
    check({tag, " c_TLAST positions wrong"}, last_err, 0);
    check({tag, " c_TUSER wrong"}, user_err, 0);
    check({tag, " spot word"}, (v.chk_idx < got_d.size()) ? 32'(got_d[v.chk_idx]) : 32'hDEAD_BEEF, 32'(v.chk_val));
    check({tag, " beats consumed"}, beat, nbeats);
    check({tag, " stall stability"}, stab_err, 0);
    check({tag, " blk_cnt"}, 32'(blk_cnt), v.exp_blk);
    check({tag, " busy after final"}, 32'(busy), 32'd0);
    check({tag, " err"}, 32'(err), 32'(v.exp_err));
  endtask

  initial begin
    vecs[0] = '{2'd3,  0, 16'h6261, 2'b11, 2'b11, 1'b0, 36, 1,  1, 16'h0006, 1'b0};
    vecs[1] = '{2'd0, 71, 16'h0041, 2'b01, 2'b11, 1'b0, 72, 1, 71, 16'h8641, 1'b0};
    vecs[2] = '{2'd3, 35, 16'h1357, 2'b11, 2'b11, 1'b0, 72, 2, 36, 16'h0006, 1'b0};
    vecs[3] = '{2'd1,  0, 16'hBEEF, 2'b00, 2'b11, 1'b0, 68, 1,  0, 16'h0006, 1'b0};
    vecs[4] = '{2'd3,  0, 16'h6261, 2'b11, 2'b11, 1'b1, 36, 1, 35, 16'h8000, 1'b0};
    vecs[5] = '{2'd2, 10, 16'h00C3, 2'b01, 2'b11, 1'b0, 52, 1, 10, 16'h06C3, 1'b0};
    vecs[6] = '{2'd3,  1, 16'h2222, 2'b10, 2'b01, 1'b0, 36, 1,  1, 16'h2222, 1'b1};

    repeat (3) @(negedge ACLK);
    #1;
    check("reset c_TVALID", 32'(c_TVALID), 32'd0);
    check("reset c_TDATA", 32'(c_TDATA), 32'd0);
    check("reset c_TID/c_TLAST", {c_TID, c_TLAST}, 32'd0);
    check("reset c_TUSER", 32'(c_TUSER), 32'd1);
    check("reset busy", 32'(busy), 32'd0);
    check("reset blk_cnt", 32'(blk_cnt), 32'd0);
    check("reset err", 32'(err), 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    #1;
    check("idle s_TREADY", 32'(s_TREADY), 32'd1);

    for (int i = 0; i < 7; i++) begin
      run_msg(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of padding discards the message; a fresh one must start cleanly.
    @(negedge ACLK);
    c_TREADY = 1'b1;
    s_TVALID = 1'b1; s_TLAST = 1'b1; s_TDATA = 16'h6261; s_TKEEP = 2'b11; s_TUSER = 2'd3;
    @(negedge ACLK);
    s_TVALID = 1'b0; s_TLAST = 1'b0;
    repeat (4) @(negedge ACLK);
    #1;
    check("pre-reset busy", 32'(busy), 32'd1);
    check("pre-reset c_TVALID", 32'(c_TVALID), 32'd1);
    #1;
    ARESET = 1'b1;
    #1;
    check("async reset c_TVALID", 32'(c_TVALID), 32'd0);
    check("async reset busy", 32'(busy), 32'd0);
    check("async reset err", 32'(err), 32'd0);
    check("async reset blk_cnt", 32'(blk_cnt), 32'd0);
    @(negedge ACLK);
    ARESET = 1'b0;
    run_msg('{2'd2, 0, 16'h1234, 2'b11, 2'b11, 1'b0, 52, 1, 51, 16'h8000, 1'b0}, "post-reset");
    check("post-reset first word", (got_d.size() > 0) ? 32'(got_d[0]) : 32'hDEAD_BEEF, 32'h1234);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
